// File: rtl/axil_pkg.sv
// axil_pkg: interconnect address map, write FSM states and response codes.
package axil_pkg;
  localparam int NUMBER_SLAVE = 3;
  localparam int AXI_ADDR_WIDTH = 32;
  // Slave 2 deliberately overlaps slave 0; the lower index wins in the decoder.
  localparam logic [AXI_ADDR_WIDTH-1:0] SLAVE_BASE [NUMBER_SLAVE] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [AXI_ADDR_WIDTH-1:0] SLAVE_MASK [NUMBER_SLAVE] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};
  localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
endpackage

// File: rtl/axil_addr_decoder.sv
// axil_addr_decoder: address to one-hot slave select; no hit selects the default slot.
module axil_addr_decoder
  import axil_pkg::*;
(
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [NUMBER_SLAVE:0]     onehot
);
  logic found;
  always_comb begin
    onehot = '0;
    found = 1'b0;
    for (int j = 0; j < NUMBER_SLAVE; j++) begin
      if (!found && ((addr & SLAVE_MASK[j]) == SLAVE_BASE[j])) begin
        onehot[j] = 1'b1;
        found = 1'b1;
      end
    end
    onehot[NUMBER_SLAVE] = !found;
  end
endmodule

// File: rtl/axil_crossbar_wr_ctrl.sv
// axil_crossbar_wr_ctrl: per-master write grant FSM; AXIL_WR_DECERR_EN builds the internal
// decode-error responder in slot NUMBER_SLAVE, otherwise err_* are tied low.
module axil_crossbar_wr_ctrl
  import axil_pkg::*;
(
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_ADDR_WIDTH-1:0] m_axil_awaddr,
  input  logic                      m_axil_awvalid,
  input  logic                      m_axil_awready,
  input  logic                      m_axil_wvalid,
  input  logic                      m_axil_wready,
  input  logic                      m_axil_bvalid,
  input  logic                      m_axil_bready,
  output logic [NUMBER_SLAVE:0]     grant_wr_trans,
  output logic                      err_awready,
  output logic                      err_wready,
  output logic [1:0]                err_bresp,
  output logic                      err_bvalid,
  output logic                      busy
);
  wr_state_t state, state_nxt;
  logic aw_done, w_done, aw_hs, w_hs, b_hs;
  logic [NUMBER_SLAVE:0] dec;
  axil_addr_decoder u_dec (.addr(m_axil_awaddr), .onehot(dec));
  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs = m_axil_wvalid && m_axil_wready;
  assign b_hs = m_axil_bvalid && m_axil_bready;
  assign busy = state != WR_IDLE;
  always_ff @(posedge aclk) state <= areset ? WR_IDLE : state_nxt;
  always_comb begin
    state_nxt = (state == WR_IDLE) ? (m_axil_awvalid ? WR_DATA : WR_IDLE)
              : (state == WR_DATA) ? (((aw_done || aw_hs) && (w_done || w_hs)) ? WR_RESP : WR_DATA)
              : (b_hs ? WR_IDLE : WR_RESP);
  end
  // Grant is latched once on leaving IDLE and held until the B handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      grant_wr_trans <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else if (state == WR_IDLE) begin
      aw_done <= 1'b0;
      w_done <= 1'b0;
      if (m_axil_awvalid) grant_wr_trans <= dec;
    end else if (state == WR_DATA) begin
      aw_done <= aw_done || aw_hs;
      w_done <= w_done || w_hs;
    end else if (b_hs) begin
      grant_wr_trans <= '0;
    end
  end
`ifdef AXIL_WR_DECERR_EN
  logic err_sel;
  assign err_sel = grant_wr_trans[NUMBER_SLAVE];
  assign err_awready = err_sel && state == WR_DATA && !aw_done;
  assign err_wready = err_sel && state == WR_DATA && !w_done;
  assign err_bvalid = err_sel && state == WR_RESP;
  assign err_bresp = err_bvalid ? AXIL_RESP_DECERR : 2'b00;
`else
  assign err_awready = 1'b0;
  assign err_wready = 1'b0;
  assign err_bvalid = 1'b0;
  assign err_bresp = 2'b00;
`endif
endmodule

// File: tb/tb_axil_crossbar_wr_ctrl.sv
// tb_axil_crossbar_wr_ctrl: table-driven decode/transaction checks plus multi-cycle corner sequences.
module tb_axil_crossbar_wr_ctrl;
  import axil_pkg::*;
`ifdef AXIL_WR_DECERR_EN
  localparam bit DE = 1'b1;
`else
  localparam bit DE = 1'b0;
`endif
  logic aclk = 1'b0, areset = 1'b1;
  logic [31:0] m_axil_awaddr = '0;
  logic m_axil_awvalid = 0, m_axil_awready = 0, m_axil_wvalid = 0, m_axil_wready = 0;
  logic m_axil_bvalid = 0, m_axil_bready = 0;
  logic [3:0] grant_wr_trans;
  logic err_awready, err_wready, err_bvalid, busy;
  logic [1:0] err_bresp;
  int errs = 0, checks = 0;

  axil_crossbar_wr_ctrl dut (
    .aclk(aclk), .areset(areset), .m_axil_awaddr(m_axil_awaddr),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .grant_wr_trans(grant_wr_trans), .err_awready(err_awready), .err_wready(err_wready),
    .err_bresp(err_bresp), .err_bvalid(err_bvalid), .busy(busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  grant;
    bit          is_err;
  } vec_t;
  vec_t vecs [5];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_err(input string name, input bit aw, input bit w, input bit b);
    chk({name, ".err_awready"}, 32'(err_awready), 32'(DE & aw));
    chk({name, ".err_wready"}, 32'(err_wready), 32'(DE & w));
    chk({name, ".err_bvalid"}, 32'(err_bvalid), 32'(DE & b));
    chk({name, ".err_bresp"}, 32'(err_bresp), (DE & b) ? 32'h3 : 32'h0);
  endtask

  task automatic quiet();
    m_axil_awvalid = 0; m_axil_awready = 0; m_axil_wvalid = 0; m_axil_wready = 0;
    m_axil_bvalid = 0; m_axil_bready = 0;
  endtask

  task automatic start(input logic [31:0] a);
    m_axil_awaddr = a; m_axil_awvalid = 1;
    tick();
  endtask

  initial begin
    vecs[0] = '{32'h0001_0004, 4'b0010, 1'b0};
    vecs[1] = '{32'h0000_0100, 4'b0001, 1'b0};
    vecs[2] = '{32'h0000_2000, 4'b0100, 1'b0};
    vecs[3] = '{32'h8000_0000, 4'b1000, 1'b1};
    vecs[4] = '{32'h0001_1000, 4'b1000, 1'b1};
    tick(); tick();
    areset = 0;
    chk("reset.grant", 32'(grant_wr_trans), 0);
    chk("reset.busy", 32'(busy), 0);
    chk_err("reset", 0, 0, 0);
    tick();
    chk("idle.grant", 32'(grant_wr_trans), 0);

    // Minimum-length transactions: AW and W together, B the cycle after.
    for (int i = 0; i < 5; i++) begin
      m_axil_wvalid = 1;
      start(vecs[i].addr);
      chk($sformatf("v%0d.grant", i), 32'(grant_wr_trans), 32'(vecs[i].grant));
      chk($sformatf("v%0d.busy", i), 32'(busy), 1);
      chk_err($sformatf("v%0d.data", i), vecs[i].is_err, vecs[i].is_err, 0);
      m_axil_awaddr = 32'h0001_0000;
      m_axil_awready = 1; m_axil_wready = 1;
      tick();
      chk($sformatf("v%0d.resp_grant", i), 32'(grant_wr_trans), 32'(vecs[i].grant));
      chk_err($sformatf("v%0d.resp", i), 0, 0, vecs[i].is_err);
      quiet(); m_axil_bvalid = 1; m_axil_bready = 1;
      tick();
      quiet();
      chk($sformatf("v%0d.rel_grant", i), 32'(grant_wr_trans), 0);
      chk($sformatf("v%0d.rel_busy", i), 32'(busy), 0);
      chk_err($sformatf("v%0d.idle", i), 0, 0, 0);
      tick();
    end

    // W completes first; a B handshake while still in DATA must not release the grant.
    start(32'h0000_0040);
    m_axil_wvalid = 1; m_axil_wready = 1;
    tick();
    m_axil_wvalid = 0; m_axil_wready = 0; m_axil_bvalid = 1; m_axil_bready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wfirst.hold%0d", i), 32'(grant_wr_trans), 32'b0001);
    end
    m_axil_bvalid = 0; m_axil_awready = 1;
    tick();
    m_axil_awvalid = 0; m_axil_awready = 0;
    chk("wfirst.resp_grant", 32'(grant_wr_trans), 32'b0001);
    m_axil_bvalid = 1;
    tick();
    quiet();
    chk("wfirst.rel", 32'(grant_wr_trans), 0);
    tick();

    // Unmapped address with AW and W pulses in separate cycles, then bready held low.
    start(32'hC000_0000);
    m_axil_awvalid = 0;
    chk_err("dec.aw_pending", 1, 1, 0);
    m_axil_awvalid = 1; m_axil_awready = 1;
    tick();
    quiet();
    chk_err("dec.w_pending", 0, 1, 0);
    m_axil_wvalid = 1; m_axil_wready = 1;
    tick();
    quiet(); m_axil_bvalid = DE ? 1'b1 : 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bstall.grant%0d", i), 32'(grant_wr_trans), 32'b1000);
      chk_err($sformatf("bstall%0d", i), 0, 0, 1);
    end
    m_axil_bready = 1;
    tick();
    quiet();
    chk("bstall.rel", 32'(grant_wr_trans), 0);
    chk("bstall.busy", 32'(busy), 0);
    tick();

    // Reset in DATA after AW only clears everything; a fresh transaction then completes.
    start(32'h9000_0000);
    m_axil_awready = 1;
    tick();
    quiet();
    chk_err("rst.before", 0, 1, 0);
    areset = 1;
    tick();
    areset = 0;
    chk("rst.grant", 32'(grant_wr_trans), 0);
    chk("rst.busy", 32'(busy), 0);
    chk_err("rst.after", 0, 0, 0);
    m_axil_wvalid = 1; m_axil_wready = 1;
    start(32'h0000_8000);
    chk("fresh.grant", 32'(grant_wr_trans), 32'b0100);
    m_axil_awready = 1;
    tick();
    quiet(); m_axil_bvalid = 1; m_axil_bready = 1;
    chk("fresh.resp", 32'(grant_wr_trans), 32'b0100);
    tick();
    quiet();
    chk("fresh.rel", 32'(grant_wr_trans), 0);
    chk("fresh.busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
